hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core (IF, ID, EX, MEM, WB). It keeps a shadow pipeline of destination-register tags for the EX, MEM and WB stages. It detects RAW hazards for the instruction in ID and drives the PC / IF_ID write enables, IF_ID flush and ID_EX bubble. It produces EX-stage forwarding selects and counts stall and flush cycles. Branch/JAL resolve in ID; JALR resolves in EX.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 32, width of performance counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  run enable; low = freeze fetch, issue bubbles
id_valid_i  in  1  ID holds a real instruction (not NOP)
id_rs1_i  in  REG_ADDR_W  ID source 1
id_rs2_i  in  REG_ADDR_W  ID source 2
id_use_rs1_i  in  1  ID instruction reads rs1
id_use_rs2_i  in  1  ID instruction reads rs2
id_rd_i  in  REG_ADDR_W  ID destination
id_reg_write_i  in  1  ID instruction writes rd
id_is_load_i  in  1  ID instruction is a load (reg_src = memory)
id_cmp_i  in  1  ID instruction consumes operands in ID (branch/JALR compare); forwarding not applicable
redirect_id_i  in  1  taken branch or JAL resolved in ID
redirect_ex_i  in  1  JALR in EX (target from ALU)
pc_write_o  out  1  PC load enable
if_id_write_o  out  1  IF_ID load enable
if_id_flush_o  out  1  IF_ID loads NOP
id_ex_bubble_o  out  1  ID_EX loads NOP controls
fwd_a_o  out  2  EX operand 1 source: 00 ID_EX, 01 EX_MEM result, 10 MEM_WB data
fwd_b_o  out  2  EX operand 2 source, same encoding
stall_cnt_o  out  CNT_W  cycles with stall asserted
flush_cnt_o  out  CNT_W  redirect events

Behaviour:
- Clock `clk_i`, reset `rst_i`: synchronous, active-high. On reset, all tag slots are invalid, fwd_a_o/fwd_b_o = 00, counters = 0. While rst_i is high: pc_write_o = 0, if_id_write_o = 0, if_id_flush_o = 1, id_ex_bubble_o = 1.
- Tag slots EX, MEM, WB each hold {valid, rd, reg_write, is_load}. They shift every cycle: WB<=MEM, MEM<=EX. EX loads the ID tag on issue; otherwise EX is set invalid.
- match(slot, rs) = slot.valid & slot.reg_write & slot.rd == rs & rs != 0 & use_rs.
- Issue occurs when id_valid_i & start_i & !stall & !redirect_ex_i.
- Stall is combinational and asserted only if id_valid_i. It is asserted if any of the following hold:
  (a) match WB, for either source (register file has no write-through);
  (b) id_cmp_i and match in EX or MEM;
  (c) EX.is_load and match EX (load-use);
  (d) without forwarding, match EX or MEM.
- Stall actions: pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1.
- Forwarding select is registered on issue, aligned with the instruction entering EX.
  - Match in EX slot gives 01. Otherwise match in MEM slot gives 10. Otherwise 00.
  - The youngest producer wins. Selects are 00 when no issue occurs.
- redirect_id_i is honoured only when not stalled: if_id_flush_o = 1; pc_write_o = 1; ID issues normally.
- redirect_ex_i has the highest priority and overrides stall:
  - if_id_flush_o = 1, id_ex_bubble_o = 1, pc_write_o = 1.
  - The EX slot loads invalid.
  - A simultaneous redirect_id_i is ignored, because that ID instruction is wrong-path.
- start_i low: pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1. Slots keep draining.
- Otherwise: pc_write_o = 1, if_id_write_o = 1, flush = 0, bubble = 0.
- Counters:
  - stall_cnt_o increments each cycle the stall condition is asserted.
  - flush_cnt_o increments once per honoured redirect.
  - Both wrap modulo 2^CNT_W.
- Reset mid-stall: the stall drops in the cycle after reset deasserts, because all slots are invalid.

Optional Feature:
HAZARD_FWD_EN
- Defined: forwarding is active; stall rule (d) is absent. Maximum non-compare stall is 1 cycle, from load-use or a WB match.
- Undefined: fwd_a_o/fwd_b_o are tied to 00 and the forwarding registers are removed. Rule (d) is active, so any pending producer stalls ID until it retires, at most 3 cycles.

Test Plan:
- add x5,x1,x2 then add x6,x5,x3:
  - with HAZARD_FWD_EN: no stall; fwd_a_o = 01 in the consumer's EX cycle.
  - without: 2 stall cycles, then 1 cycle for WB match, giving stall_cnt_o = 3.
- lw x5,0(x1) then add x6,x5,x0: exactly 1 stall cycle (load-use), then fwd_a_o = 10; stall_cnt_o = 1.
- add x5,.. then beq x5,x0 with taken branch:
  - the branch stalls until x5 leaves WB (3 cycles);
  - then if_id_flush_o pulses 1 cycle; flush_cnt_o = 1.
- jalr in EX while the ID instruction is stalled on a WB match:
  - if_id_flush_o = 1, id_ex_bubble_o = 1, pc_write_o = 1 in the same cycle;
  - the ID instruction never issues.
- add x0,x1,x2 then add x6,x0,x0: no stall, fwd_a_o = fwd_b_o = 00 (x0 is never a hazard).
- Assert rst_i during the load-use stall:
  - outputs go to reset values at the next edge; counters clear;
  - the first cycle after release has pc_write_o = 1 once start_i = 1.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : RAW hazard / stall / flush sequencing for the 5-stage RV32 core
// Optional HAZARD_FWD_EN: EX-stage forwarding selects, fewer stall cycles
// Revision 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_is_load_i,
  input  logic                  id_cmp_i,
  input  logic                  redirect_id_i,
  input  logic                  redirect_ex_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_bubble_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } tag_t;

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  tag_t       slot [0:2];
  tag_t       id_tag;
  logic [2:0] match_rs1;
  logic [2:0] match_rs2;
  logic       hit_ex;
  logic       hit_mem;
  logic       hit_wb;
  logic       rule_d;
  logic       stall;
  logic       issue;
  logic       take_id;
  logic       honoured;

  assign id_tag = '{valid: 1'b1, rd: id_rd_i, reg_write: id_reg_write_i, is_load: id_is_load_i};

  // x0 is hardwired zero, so it can never carry a dependency
  generate
    for (genvar s = 0; s < 3; s++) begin : g_match
      assign match_rs1[s] = slot[s].valid & slot[s].reg_write & (slot[s].rd == id_rs1_i)
                          & (id_rs1_i != '0) & id_use_rs1_i;
      assign match_rs2[s] = slot[s].valid & slot[s].reg_write & (slot[s].rd == id_rs2_i)
                          & (id_rs2_i != '0) & id_use_rs2_i;
    end
  endgenerate

  assign hit_ex  = match_rs1[SLOT_EX]  | match_rs2[SLOT_EX];
  assign hit_mem = match_rs1[SLOT_MEM] | match_rs2[SLOT_MEM];
  assign hit_wb  = match_rs1[SLOT_WB]  | match_rs2[SLOT_WB];

`ifdef HAZARD_FWD_EN
  assign rule_d = 1'b0;
`else
  assign rule_d = hit_ex | hit_mem;
`endif

  // The register file has no write-through, so a WB producer always stalls
  assign stall = id_valid_i & (hit_wb
                             | (id_cmp_i & (hit_ex | hit_mem))
                             | (slot[SLOT_EX].is_load & hit_ex)
                             | rule_d);

  assign issue    = id_valid_i & start_i & ~stall & ~redirect_ex_i;
  assign take_id  = redirect_id_i & ~redirect_ex_i & start_i & ~stall;
  assign honoured = redirect_ex_i | take_id;

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (redirect_ex_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (!start_i || stall) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else if (redirect_id_i) begin
      if_id_flush_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot[SLOT_EX]  <= '0;
      slot[SLOT_MEM] <= '0;
      slot[SLOT_WB]  <= '0;
      stall_cnt_o    <= '0;
      flush_cnt_o    <= '0;
    end else begin
      slot[SLOT_WB]  <= slot[SLOT_MEM];
      slot[SLOT_MEM] <= slot[SLOT_EX];
      slot[SLOT_EX]  <= issue ? id_tag : '0;
      stall_cnt_o    <= stall_cnt_o + {{(CNT_W-1){1'b0}}, stall};
      flush_cnt_o    <= flush_cnt_o + {{(CNT_W-1){1'b0}}, honoured};
    end
  end

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m);
    if (ex_m)       return 2'b01;
    else if (mem_m) return 2'b10;
    else            return 2'b00;
  endfunction

  // Selects travel with the instruction into EX; the youngest producer wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_a_o <= 2'b00;
      fwd_b_o <= 2'b00;
    end else if (issue) begin
      fwd_a_o <= fwd_sel(match_rs1[SLOT_EX], match_rs1[SLOT_MEM]);
      fwd_b_o <= fwd_sel(match_rs2[SLOT_EX], match_rs2[SLOT_MEM]);
    end else begin
      fwd_a_o <= 2'b00;
      fwd_b_o <= 2'b00;
    end
  end
`else
  assign fwd_a_o = 2'b00;
  assign fwd_b_o = 2'b00;
`endif

  logic unused_tag_bits;
  assign unused_tag_bits = ^{slot[SLOT_MEM].is_load, slot[SLOT_WB].is_load};

endmodule
`default_nettype wire
